// File: rtl/oam_dma_m.sv
// ---------------------------------------------------------------------------
// oam_dma_m
//
// Purpose:
//   Sprite-attribute (OAM) DMA engine. A CPU write to the DMA register at
//   16'hFF46 names a source page. The engine then copies 160 bytes from
//   {page, 00..9F} to FE00..FE9F, one byte every CYCLES_PER_BYTE clocks.
//   Every byte slot runs the same sequence:
//     - present the source address,
//     - capture the read data after READ_LATENCY clocks,
//     - strobe a single OAM write,
//     - idle on the destination address until the slot ends.
//
// Parameters:
//   CYCLES_PER_BYTE  clocks per transferred byte. Must be >= READ_LATENCY+2.
//   READ_LATENCY     clocks from the source address appearing on
//                    dma_req_addr_select_o to valid dma_req_read_out_i.
//
// Ports:
//   clk                          sole clock, rising edge
//   rst                          synchronous active-high reset
//   mmio_dma_if_addr_select_i    CPU register address (DMA reg at FF46)
//   mmio_dma_if_write_value_i    CPU write data
//   mmio_dma_if_write_enable_i   CPU write strobe
//   mmio_dma_if_read_out_o       DMA register readback (combinational)
//   dma_req_addr_select_o        DMA bus address, FFFF when no transfer
//   dma_req_write_value_o        byte written to OAM
//   dma_req_write_enable_o       OAM write strobe
//   dma_req_read_out_i           source read data
//   dma_active_o                 high while in START or XFER
// ---------------------------------------------------------------------------
module oam_dma_m #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_dma_if_addr_select_i,
  input  logic [7:0]  mmio_dma_if_write_value_i,
  input  logic        mmio_dma_if_write_enable_i,
  output logic [7:0]  mmio_dma_if_read_out_o,
  output logic [15:0] dma_req_addr_select_o,
  output logic [7:0]  dma_req_write_value_o,
  output logic        dma_req_write_enable_o,
  input  logic [7:0]  dma_req_read_out_i,
  output logic        dma_active_o
);

  localparam int SW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;

  // Slot-cycle landmarks, pre-sized to the slot counter width.
  localparam logic [SW-1:0] SLOT_LAST = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [SW-1:0] SLOT_CAP  = SW'(READ_LATENCY);
  localparam logic [SW-1:0] SLOT_WR   = SW'(READ_LATENCY + 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  localparam logic [15:0] REG_ADDR   = 16'hFF46;
  localparam logic [7:0]  LAST_INDEX = 8'd159;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    dmaReg_q;
  logic [7:0]    sp_q, sp_d;
  logic [7:0]    index_q, index_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [7:0]    data_q, data_d;

  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wval_q, wval_d;
  logic          we_q, we_d;
  logic          active_q, active_d;

  logic          regWrite;

  assign regWrite = mmio_dma_if_write_enable_i &&
                    (mmio_dma_if_addr_select_i == REG_ADDR);

  // Sequencer next state.
  // A register write always wins, including over the final slot
  // completing. This is how a new write restarts a running transfer.
  // The in-flight byte is dropped because START never strobes a write.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    index_d = index_q;
    slot_d  = slot_q;
    if (regWrite) begin
      // Pages E0..FF mirror work RAM, so fold them down by 20h.
      sp_d    = (mmio_dma_if_write_value_i >= 8'hE0) ?
                (mmio_dma_if_write_value_i - 8'h20) :
                mmio_dma_if_write_value_i;
      index_d = 8'd0;
      slot_d  = '0;
      state_d = START;
    end else begin
      case (state_q)
        START: begin
          state_d = XFER;
          index_d = 8'd0;
          slot_d  = '0;
        end
        XFER: begin
          if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (index_q == LAST_INDEX) begin
              state_d = IDLE;
              index_d = 8'd0;
            end else begin
              index_d = index_q + 8'd1;
            end
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output and capture next values, derived from the next sequencer
  // state so that all bus outputs are plain registers.
  // In each slot:
  //   - the source address is held through the capture cycle;
  //   - the bus then switches to the OAM address, which stays put
  //     until the slot ends;
  //   - the address therefore never falls back to FFFF between bytes.
  always_comb begin
    addr_d   = 16'hFFFF;
    we_d     = 1'b0;
    wval_d   = wval_q;
    data_d   = data_q;
    active_d = (state_d != IDLE);
    case (state_d)
      XFER: begin
        if (slot_d <= SLOT_CAP) begin
          addr_d = {sp_d, index_d};
        end else begin
          addr_d = {8'hFE, index_d};
        end
        we_d = (slot_d == SLOT_WR);
        // slot_d==SLOT_WR means the current cycle is the capture cycle.
        if (slot_d == SLOT_WR) begin
          data_d = dma_req_read_out_i;
          wval_d = dma_req_read_out_i;
        end
      end
      default: begin
        wval_d = 8'h00;
      end
    endcase
  end

  // State, register file and output registers; reset beats a CPU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dmaReg_q <= 8'hFF;
      sp_q     <= 8'h00;
      index_q  <= 8'd0;
      slot_q   <= '0;
      data_q   <= 8'h00;
      addr_q   <= 16'hFFFF;
      wval_q   <= 8'h00;
      we_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      if (regWrite) begin
        dmaReg_q <= mmio_dma_if_write_value_i;
      end
      state_q  <= state_d;
      sp_q     <= sp_d;
      index_q  <= index_d;
      slot_q   <= slot_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wval_q   <= wval_d;
      we_q     <= we_d;
      active_q <= active_d;
    end
  end

  assign mmio_dma_if_read_out_o = dmaReg_q;
  assign dma_req_addr_select_o  = addr_q;
  assign dma_req_write_value_o  = wval_q;
  assign dma_req_write_enable_o = we_q;
  assign dma_active_o           = active_q;

endmodule

// File: tb/tb_oam_dma_m.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_m
//
// Purpose:
//   Directed testbench for oam_dma_m.
//
// Source memory model:
//   - The model has a two-stage read pipeline.
//   - Its read data is the low byte of the requested address.
//
// Expected OAM writes:
//   - They are queued whenever a transfer is launched.
//   - They are popped as the DUT strobes write_enable.
// ---------------------------------------------------------------------------
module tb_oam_dma_m;

  logic        clk;
  logic        rst;
  logic [15:0] mAddr;
  logic [7:0]  mVal;
  logic        mWe;
  logic [7:0]  mRead;
  logic [15:0] dAddr;
  logic [7:0]  dWv;
  logic        dWe;
  logic [7:0]  dRead;
  logic        dActive;

  logic [7:0]  rd1;
  logic [7:0]  expPage;
  logic [23:0] sb[$];

  int checks = 0;
  int errors = 0;
  int writeCount = 0;

  oam_dma_m #(
    .CYCLES_PER_BYTE(4),
    .READ_LATENCY(2)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .mmio_dma_if_addr_select_i  (mAddr),
    .mmio_dma_if_write_value_i  (mVal),
    .mmio_dma_if_write_enable_i (mWe),
    .mmio_dma_if_read_out_o     (mRead),
    .dma_req_addr_select_o      (dAddr),
    .dma_req_write_value_o      (dWv),
    .dma_req_write_enable_o     (dWe),
    .dma_req_read_out_i         (dRead),
    .dma_active_o               (dActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: two-clock read latency, data equals low address byte.
  always @(posedge clk) begin
    rd1   <= dAddr[7:0];
    dRead <= rd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every OAM write; watch source addresses in flight.
  always @(negedge clk) begin
    if (!rst && dWe) begin
      writeCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", {8'h00, dAddr, dWv}, 32'hFFFFFFFF);
      end else begin
        checkOutput("oam_write", {8'h00, dAddr, dWv}, {8'h00, sb.pop_front()});
      end
    end
    if (!rst && dActive && dAddr != 16'hFFFF && dAddr[15:8] != 8'hFE) begin
      checkOutput("src_addr", {23'd0, dAddr[15:8], dAddr[7:0] < 8'hA0},
                  {23'd0, expPage, 1'b1});
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    mAddr = a;
    mVal  = v;
    mWe   = 1'b1;
    @(posedge clk);
    #1;
    mWe   = 1'b0;
    mAddr = 16'h0000;
  endtask

  task automatic pushXfer(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back({16'hFE00 + 16'(i), 8'(i)});
    end
  endtask

  task automatic measureActive(output int cnt, output int firstWe);
    cnt = 0;
    firstWe = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!dActive) break;
      if (dWe && firstWe < 0) firstWe = cnt;
      cnt++;
    end
  endtask

  int cnt;
  int firstWe;
  int wcBefore;

  initial begin
    rst   = 1'b1;
    mAddr = 16'h0000;
    mVal  = 8'h00;
    mWe   = 1'b0;
    expPage = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_addr", {16'd0, dAddr}, 32'h0000FFFF);
    checkOutput("reset_we", {31'd0, dWe}, 32'd0);
    checkOutput("reset_active", {31'd0, dActive}, 32'd0);
    checkOutput("reset_reg", {24'd0, mRead}, 32'h000000FF);
    @(negedge clk);
    rst = 1'b0;

    // Basic transfer from page C1.
    pushXfer(160);
    applyStimulus(16'hFF46, 8'hC1);
    expPage = 8'hC1;
    measureActive(cnt, firstWe);
    checkOutput("c1_active_len", cnt, 641);
    checkOutput("c1_first_write", firstWe, 4);
    checkOutput("c1_idle_addr", {16'd0, dAddr}, 32'h0000FFFF);
    checkOutput("c1_idle_wv", {24'd0, dWv}, 32'd0);
    checkOutput("c1_sb_empty", sb.size(), 0);
    checkOutput("c1_write_count", writeCount, 160);

    // Readback of a plain page value (also runs a transfer from 80).
    pushXfer(160);
    applyStimulus(16'hFF46, 8'h80);
    expPage = 8'h80;
    checkOutput("reg_80", {24'd0, mRead}, 32'h80);
    measureActive(cnt, firstWe);
    checkOutput("p80_active_len", cnt, 641);
    checkOutput("p80_sb_empty", sb.size(), 0);

    // Echo page: E2 reads from C2.
    pushXfer(160);
    applyStimulus(16'hFF46, 8'hE2);
    expPage = 8'hC2;
    checkOutput("reg_e2", {24'd0, mRead}, 32'hE2);
    measureActive(cnt, firstWe);
    checkOutput("e2_active_len", cnt, 641);
    checkOutput("e2_sb_empty", sb.size(), 0);

    // Neighbouring registers must not trigger anything.
    applyStimulus(16'hFF45, 8'h12);
    applyStimulus(16'hFF47, 8'h34);
    repeat (4) @(negedge clk);
    checkOutput("nbr_reg", {24'd0, mRead}, 32'hE2);
    checkOutput("nbr_active", {31'd0, dActive}, 32'd0);
    checkOutput("nbr_addr", {16'd0, dAddr}, 32'h0000FFFF);

    // Restart: C0 then D0 during byte 50 slot cycle 1.
    pushXfer(50);
    applyStimulus(16'hFF46, 8'hC0);
    expPage = 8'hC0;
    repeat (202) @(posedge clk);
    pushXfer(160);
    applyStimulus(16'hFF46, 8'hD0);
    expPage = 8'hD0;
    measureActive(cnt, firstWe);
    checkOutput("restart_active_len", cnt, 641);
    checkOutput("restart_first_write", firstWe, 4);
    checkOutput("restart_sb_empty", sb.size(), 0);

    // Reset abort at byte 10.
    pushXfer(10);
    applyStimulus(16'hFF46, 8'hC1);
    expPage = 8'hC1;
    repeat (41) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_addr", {16'd0, dAddr}, 32'h0000FFFF);
    checkOutput("abort_we", {31'd0, dWe}, 32'd0);
    checkOutput("abort_wv", {24'd0, dWv}, 32'd0);
    checkOutput("abort_active", {31'd0, dActive}, 32'd0);
    checkOutput("abort_reg", {24'd0, mRead}, 32'hFF);
    checkOutput("abort_sb_empty", sb.size(), 0);

    // Reset held with a coincident register write: reset wins.
    mAddr = 16'hFF46;
    mVal  = 8'h55;
    mWe   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_prio_reg", {24'd0, mRead}, 32'hFF);
    checkOutput("rst_prio_active", {31'd0, dActive}, 32'd0);
    @(negedge clk);
    mWe = 1'b0;
    mAddr = 16'h0000;
    rst = 1'b0;
    wcBefore = writeCount;
    repeat (700) @(negedge clk);
    checkOutput("abort_no_writes", writeCount, wcBefore);
    checkOutput("abort_idle_active", {31'd0, dActive}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
